// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster generator.
// Holds the default 640x480@60 timing constants and totals, the coordinate type,
// the sync/DE bundle carried through the delay line, and the colour-bar table
// used by the optional test pattern (VGA_TEST_PATTERN_EN).
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic de;
  } sync_bundle_t;

  // Blanked, both syncs inactive (high).
  localparam sync_bundle_t SYNC_IDLE = '{h_sync: 1'b1, v_sync: 1'b1, de: 1'b0};

  // Index 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_RGB = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                          12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the generator (master) and its consumers (slave).
// en            : run enable, driven by the consumer side
// pix_tick      : one-clk strobe per pixel
// x_coor/y_coor : active-area coordinates (0 outside)
// DE/h_sync/v_sync, line_start/frame_start, delayed d_* copies, pattern_rgb
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic        en;
  logic        pix_tick;
  coord_t      x_coor;
  coord_t      y_coor;
  logic        DE;
  logic        h_sync;
  logic        v_sync;
  logic        line_start;
  logic        frame_start;
  logic        d_h_sync;
  logic        d_v_sync;
  logic        d_DE;
  logic [11:0] pattern_rgb;

  modport master (
    input  en,
    output pix_tick, x_coor, y_coor, DE, h_sync, v_sync, line_start, frame_start,
    output d_h_sync, d_v_sync, d_DE, pattern_rgb
  );

  modport slave (
    output en,
    input  pix_tick, x_coor, y_coor, DE, h_sync, v_sync, line_start, frame_start,
    input  d_h_sync, d_v_sync, d_DE, pattern_rgb
  );

endinterface

// File: rtl/sync_delay_line.sv
// Shift register that delays a small bundle by DEPTH shift_en strobes.
// clk      : clock
// reset    : synchronous, active-high; loads every stage with RESET_VAL
// shift_en : advance the line by one stage
// d / q    : bundle in / bundle DEPTH strobes old (q = d when DEPTH is 0)
module sync_delay_line #(
  parameter int unsigned       DEPTH     = 1,
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, shift_en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RESET_VAL;
      end else if (shift_en) begin
        stage_q[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60 from a 100 MHz clk, CLK_DIV=4).
// clk   : system clock
// reset : synchronous, active-high
// bus   : vga_timing_gen_if master -- en in; pix_tick, x_coor, y_coor, DE, h_sync,
//         v_sync, line_start, frame_start, d_h_sync, d_v_sync, d_DE, pattern_rgb out
// All outputs are registered and decoded from the next-state counters, so they move
// on the same edge the counters do. d_* are h_sync/v_sync/DE delayed PIPE_DLY ticks.
// Optional: define VGA_TEST_PATTERN_EN for eight vertical colour bars on pattern_rgb;
// otherwise pattern_rgb is tied to 12'h000.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned PIPE_DLY  = 0
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_timing_gen: H/V totals must fit the 10-bit counters");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV out of range 1..16");
  end
  if (PIPE_DLY > 15) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY out of range 0..15");
  end

  localparam coord_t     H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t     V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t     H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t     V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t     HS_FIRST = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t     HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t     VS_FIRST = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t     VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  // Disabling behaves exactly like reset: everything returns to idle.
  logic clear;
  assign clear = reset | ~bus.en;

  logic [3:0]   div_q, div_d;
  logic         tick;
  // Low until the first tick after a restart; that tick presents (0,0) without advancing.
  logic         run_q, run_d;
  coord_t       h_q, h_d, v_q, v_d;
  logic         pix_q, line_q, line_d, frame_q, frame_d;
  sync_bundle_t sync_q, sync_d, dly_q;
  coord_t       x_q, x_d, y_q, y_d;

  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? 4'd0 : div_q + 4'd1;
    run_d   = run_q | tick;
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (tick && run_q) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        line_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    sync_d = sync_q;
    x_d    = x_q;
    y_d    = y_q;
    if (tick) begin
      sync_d.de     = (h_d < H_VIS) && (v_d < V_VIS);
      sync_d.h_sync = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
      sync_d.v_sync = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
      x_d           = sync_d.de ? h_d : '0;
      y_d           = (v_d < V_VIS) ? v_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      div_q   <= '0;
      run_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      pix_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      sync_q  <= SYNC_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      div_q   <= div_d;
      run_q   <= run_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pix_q   <= tick;
      line_q  <= line_d;
      frame_q <= frame_d;
      sync_q  <= sync_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Fed with the registered outputs and shifted on the tick edge, so each stage is
  // exactly one tick older and the taps move on the same edge as the outputs.
  sync_delay_line #(
    .DEPTH     (PIPE_DLY),
    .WIDTH     (3),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk      (clk),
    .reset    (clear),
    .shift_en (tick),
    .d        (sync_q),
    .q        (dly_q)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam coord_t BAR_W = coord_t'(H_VISIBLE / 8);

  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = rgb_q;
    if (tick) begin
      rgb_d = sync_d.de ? bar_colour(3'(h_d / BAR_W)) : 12'h000;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) rgb_q <= 12'h000;
    else       rgb_q <= rgb_d;
  end

  assign bus.pattern_rgb = rgb_q;
`else
  assign bus.pattern_rgb = 12'h000;
`endif

  assign bus.pix_tick    = pix_q;
  assign bus.x_coor      = x_q;
  assign bus.y_coor      = y_q;
  assign bus.DE          = sync_q.de;
  assign bus.h_sync      = sync_q.h_sync;
  assign bus.v_sync      = sync_q.v_sync;
  assign bus.line_start  = line_q;
  assign bus.frame_start = frame_q;
  assign bus.d_h_sync    = dly_q.h_sync;
  assign bus.d_v_sync    = dly_q.v_sync;
  assign bus.d_DE        = dly_q.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two shrunk-raster instances (CLK_DIV=4/PIPE_DLY=5 and
// CLK_DIV=1/PIPE_DLY=0) checked every clk against a closed-form raster model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;  // 24
  localparam int VT = VV + VF + VS + VB;  // 10
  localparam int DIV_A = 4, DLY_A = 5, DIV_B = 1, DLY_B = 0;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if bus_a ();
  vga_timing_gen_if bus_b ();
  assign bus_a.en = en;
  assign bus_b.en = en;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV_A), .PIPE_DLY(DLY_A)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV_B), .PIPE_DLY(DLY_B)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    int          x;
    int          y;
    logic [11:0] rgb;
  } pix_t;

  // Outputs after the n-th pixel tick since restart; n <= 0 is the idle state.
  function automatic pix_t decode(input int n);
    pix_t r;
    int p, h, v;
    r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0; r.x = 0; r.y = 0; r.rgb = 12'h000;
    if (n > 0) begin
      p = n - 1;
      h = p % HT;
      v = (p / HT) % VT;
      r.de = (h < HV) && (v < VV);
      r.hs = !((h >= HV + HF) && (h < HV + HF + HS));
      r.vs = !((v >= VV + VF) && (v < VV + VF + VS));
      r.x  = r.de ? h : 0;
      r.y  = (v < VV) ? v : 0;
`ifdef VGA_TEST_PATTERN_EN
      if (r.de) r.rgb = BARS[h / (HV / 8)];
`endif
    end
    return r;
  endfunction

  task automatic check_all(input string tag, input int clks, input int ticks,
                           input int div, input int dly,
                           input logic pix, input logic ls, input logic fs,
                           input logic de, input logic hs, input logic vs,
                           input logic dde, input logic dhs, input logic dvs,
                           input logic [9:0] x, input logic [9:0] y, input logic [11:0] rgb);
    pix_t cur, del;
    bit tick_now, ls_e, fs_e;
    int p;
    tick_now = (clks > 0) && (clks % div == 0);
    cur = decode(ticks);
    del = decode(ticks - dly);
    p = ticks - 1;
    ls_e = tick_now && (ticks > 1) && (p % HT == 0);
    fs_e = ls_e && ((p / HT) % VT == 0);
    check({tag, ".pix_tick"}, 32'(pix), 32'(tick_now));
    check({tag, ".line_start"}, 32'(ls), 32'(ls_e));
    check({tag, ".frame_start"}, 32'(fs), 32'(fs_e));
    check({tag, ".DE"}, 32'(de), 32'(cur.de));
    check({tag, ".h_sync"}, 32'(hs), 32'(cur.hs));
    check({tag, ".v_sync"}, 32'(vs), 32'(cur.vs));
    check({tag, ".x_coor"}, 32'(x), cur.x);
    check({tag, ".y_coor"}, 32'(y), cur.y);
    check({tag, ".pattern_rgb"}, 32'(rgb), 32'(cur.rgb));
    check({tag, ".d_DE"}, 32'(dde), 32'(del.de));
    check({tag, ".d_h_sync"}, 32'(dhs), 32'(del.hs));
    check({tag, ".d_v_sync"}, 32'(dvs), 32'(del.vs));
  endtask

  // Model state: enabled clks and pixel ticks since the last reset/disable.
  int clks_a = 0, ticks_a = 0, clks_b = 0, ticks_b = 0;

  always @(posedge clk) begin
    if (reset || !en) begin
      clks_a = 0; ticks_a = 0; clks_b = 0; ticks_b = 0;
    end else begin
      clks_a++;
      if (clks_a % DIV_A == 0) ticks_a++;
      clks_b++;
      if (clks_b % DIV_B == 0) ticks_b++;
    end
    #1;
    check_all("a", clks_a, ticks_a, DIV_A, DLY_A, bus_a.pix_tick, bus_a.line_start,
              bus_a.frame_start, bus_a.DE, bus_a.h_sync, bus_a.v_sync, bus_a.d_DE,
              bus_a.d_h_sync, bus_a.d_v_sync, bus_a.x_coor, bus_a.y_coor, bus_a.pattern_rgb);
    check_all("b", clks_b, ticks_b, DIV_B, DLY_B, bus_b.pix_tick, bus_b.line_start,
              bus_b.frame_start, bus_b.DE, bus_b.h_sync, bus_b.v_sync, bus_b.d_DE,
              bus_b.d_h_sync, bus_b.d_v_sync, bus_b.x_coor, bus_b.y_coor, bus_b.pattern_rgb);
  end

  initial begin
    pix_t m;
    int n, last_a, last_b, de_cnt;
    bit got;

    // Pin the model with hand-derived points of the 24x10 raster.
    m = decode(1);              // (0,0)
    check("pin.p0.de", 32'(m.de), 1);
    check("pin.p0.hs", 32'(m.hs), 1);
    m = decode(19);             // h=18: first h_sync pixel
    check("pin.h18.hs", 32'(m.hs), 0);
    check("pin.h18.de", 32'(m.de), 0);
    m = decode(22);             // h=21: back porch
    check("pin.h21.hs", 32'(m.hs), 1);
    m = decode(5 * 24 + 16);    // (15,5): last active pixel
    check("pin.last.x", m.x, 15);
    check("pin.last.y", m.y, 5);
    m = decode(8 * 24 + 1);     // v=8: second v_sync line, blanked
    check("pin.v8.vs", 32'(m.vs), 0);
    check("pin.v8.y", m.y, 0);
    m = decode(240 + 1);        // wrapped back to (0,0)
    check("pin.wrap.de", 32'(m.de), 1);

    repeat (3) @(negedge clk);
    check("rst.DE", 32'(bus_a.DE), 0);
    check("rst.h_sync", 32'(bus_a.h_sync), 1);
    check("rst.d_v_sync", 32'(bus_a.d_v_sync), 1);

    reset = 1'b0;
    en = 1'b1;
    n = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_a.pix_tick) begin got = 1; n = i; end
    end
    check("a.first_tick_clks", n, 4);

    // Frame periods and DE pixels per frame.
    last_a = -1; last_b = -1; de_cnt = 0;
    for (int c = 0; c < 2200; c++) begin
      @(posedge clk); #1;
      if (bus_b.pix_tick && bus_b.DE) de_cnt++;
      if (bus_b.frame_start) begin
        if (last_b >= 0) begin
          check("b.frame_period", c - last_b, 240);
          check("b.de_per_frame", de_cnt, 97);  // includes the wrap tick at (0,0)
        end
        last_b = c;
        de_cnt = 1;
      end
      if (bus_a.frame_start) begin
        if (last_a >= 0) check("a.frame_period", c - last_a, 960);
        last_a = c;
      end
    end
    @(negedge clk);

    // Reset mid-frame at (10,3).
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_a.DE && bus_a.x_coor == 10'd10 && bus_a.y_coor == 10'd3) got = 1;
    end
    check("a.reach_10_3", 32'(got), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst.DE", 32'(bus_a.DE), 0);
    check("midrst.x_coor", 32'(bus_a.x_coor), 0);
    check("midrst.d_DE", 32'(bus_a.d_DE), 0);
    check("midrst.d_h_sync", 32'(bus_a.d_h_sync), 1);
    @(negedge clk);
    reset = 1'b0;
    n = 0; got = 0;
    for (int i = 1; i <= 1200 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_a.frame_start) begin got = 1; n = i; end
    end
    check("a.first_frame_start_clks", n, 964);
    @(negedge clk);

    // en gap of 10 clks mid-line.
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_a.DE && bus_a.x_coor == 10'd7) got = 1;
    end
    check("a.reach_x7", 32'(got), 1);
    @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    check("gap.DE", 32'(bus_a.DE), 0);
    check("gap.h_sync", 32'(bus_a.h_sync), 1);
    en = 1'b1;
    n = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_a.pix_tick) begin got = 1; n = i; end
    end
    check("gap.first_tick_clks", n, 4);
    check("gap.x_coor", 32'(bus_a.x_coor), 0);
`ifdef VGA_TEST_PATTERN_EN
    check("gap.rgb_x0", 32'(bus_a.pattern_rgb), 32'h FFF);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_a.DE && bus_a.x_coor == 10'd2) got = 1;
    end
    check("pat.rgb_x2", 32'(bus_a.pattern_rgb), 32'h FF0);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (bus_a.DE && bus_a.x_coor == 10'd15) got = 1;
    end
    check("pat.rgb_x15", 32'(bus_a.pattern_rgb), 32'h000);
`endif
    @(negedge clk);

    // Randomized runs, resets and enable gaps.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 5))
        0: begin
          reset = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          reset = 1'b0;
        end
        1: begin
          en = 1'b0;
          repeat ($urandom_range(1, 12)) @(negedge clk);
          en = 1'b1;
        end
        default: repeat ($urandom_range(1, 300)) @(negedge clk);
      endcase
    end
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the VGA 640x480@60 raster that the pixel-stream filters consume: pixel tick, `x_coor`/`y_coor`, `DE`, `h_sync`, `v_sync`.
- Also provides copies of `h_sync`/`v_sync`/`DE` delayed by a parameterised number of pixels. These realign sync with video that has passed through pipelined filters, e.g. the morphology chain.
- Sits between the system clock domain and the VGA port.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); legal range 1..16
- PIPE_DLY, 0, delay of the d_* outputs in pixel ticks; legal range 0..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  run enable
- pix_tick  out  1  one-clk strobe, once per pixel
- x_coor  out  10  column, 0..H_VISIBLE-1 while DE, else 0
- y_coor  out  10  row, 0..V_VISIBLE-1 while in active lines, else 0
- DE  out  1  display enable (visible region)
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- line_start  out  1  one-clk pulse when h counter wraps to 0
- frame_start  out  1  one-clk pulse when (h,v) wraps to (0,0)
- d_h_sync  out  1  h_sync delayed PIPE_DLY ticks
- d_v_sync  out  1  v_sync delayed PIPE_DLY ticks
- d_DE  out  1  DE delayed PIPE_DLY ticks
- pattern_rgb  out  12  test-pattern pixel (see Optional Feature)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while `en`=1.
  - `pix_tick`=1 in the clk where div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives `pix_tick` permanently high while `en`.
- Counters:
  - On `pix_tick`: h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1 with h wrap, v_cnt wraps to 0.
- Output registration: all timing outputs are registered and decoded from the next-state counters, so they change on the same clk edge the counters advance. No extra latency.
- Decode:
  - DE = (h < H_VISIBLE) && (v < V_VISIBLE).
  - h_sync = 0 iff h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1].
  - v_sync = 0 iff v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1].
  - x_coor = h when DE, else 0. y_coor = v when v < V_VISIBLE, else 0.
- Pulses:
  - line_start asserts on the edge where h becomes 0.
  - frame_start asserts on the edge where (h,v) become (0,0).
  - No pulses for the initial (0,0) state after reset.
- Reset values:
  - div_cnt, h_cnt, v_cnt = 0.
  - pix_tick, DE, line_start, frame_start, d_DE = 0.
  - h_sync, v_sync, d_h_sync, d_v_sync = 1.
  - x_coor, y_coor = 0; pattern_rgb = 12'h000; delay line cleared to the idle state {1,1,0}.
- Reset asserted mid-frame: all of the above are applied on the next clk edge. Restart is at (0,0) once reset drops.
- en=0:
  - div_cnt, h_cnt, v_cnt cleared to 0.
  - Outputs forced to reset values; delay line flushed to idle.
  - After en rises, the first pix_tick occurs CLK_DIV clks later.
- Delay line:
  - PIPE_DLY-deep shift register of {h_sync, v_sync, DE}, advanced only on pix_tick.
  - PIPE_DLY=0: d_* are wired equal to the undelayed outputs.
  - Tap values update on the same edge as the undelayed outputs.
- Counter widths: h_cnt and v_cnt are 10 bits; H_TOTAL and V_TOTAL are each ≤1024, checked with an elaboration-time assertion.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - pattern_rgb shows eight vertical colour bars, each H_VISIBLE/8 wide.
  - Bar order: 12'hFFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Registered alongside DE; pattern_rgb = 12'h000 when DE=0.
- Not defined: pattern_rgb is tied to 12'h000; port list is unchanged.

Decomposition:
- Package vga_timing_pkg holds:
  - default H_* and V_* constants, H_TOTAL and V_TOTAL;
  - typedef coord_t (logic [9:0]);
  - typedef sync_bundle_t (struct: h_sync, v_sync, de);
  - colour-bar lookup constant.
- One sub-module: sync_delay_line (parameters DEPTH, WIDTH; ports clk, reset, shift_en, d, q), instantiated for the d_* outputs.

Test Plan:
- Reset, en=1, CLK_DIV=4 -> pix_tick period 4 clks. First DE high at tick 0: 640 DE ticks per line, 480 lines with DE per frame. frame_start pulses every 1,680,000 clks.
- Horizontal timing -> h_sync low for exactly 96 ticks starting 656 ticks after line start. v_sync low for 2 lines (1600 ticks) starting at line 490.
- Coordinates -> x_coor runs 0..639 during DE and is 0 otherwise. y_coor reads 479 on the last active line and 0 during vertical blanking.
- PIPE_DLY=5 -> d_DE, d_h_sync and d_v_sync equal DE, h_sync and v_sync exactly 5 ticks (20 clks) earlier, across a line wrap and a frame wrap.
- Assert reset at h=300, v=200 -> next clk: all outputs at reset values and d_* idle. After release the raster restarts at (0,0), with no frame_start for that first frame.
- en deasserted for 10 clks mid-line, then reasserted -> outputs idle during the gap. First pix_tick comes 4 clks after en rises and x_coor restarts at 0. With VGA_TEST_PATTERN_EN, pattern_rgb at x=0/80/639 reads FFF/FF0/000.
